// File: rtl/cell_exerciser_pkg.sv
// Shared types and helpers for the standard-cell functional exerciser.
// Imported by cell_exerciser and cell_exerciser_sync.
package cell_exerciser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam int MAX_IN_DEF = 4;
  localparam int TT_W = 2**MAX_IN_DEF;

  // Increment, clamping at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] m;
    if (w >= 32) m = 32'hFFFF_FFFF;
    else         m = (32'd1 << w) - 32'd1;
    return (v >= m) ? m : v + 32'd1;
  endfunction

endpackage

// File: rtl/cell_exerciser_sync.sv
// Parametrised-width two-flop synchroniser, reset to zero.
// Used on cell outputs when CELL_EXERCISER_SYNC_EN is defined.
module cell_exerciser_sync
  import cell_exerciser_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cell_exerciser.sv
// Per-cell truth-table exerciser: drives every input vector, samples Y.
// Define CELL_EXERCISER_SYNC_EN to synchronise cell_y_i (+2 settle cycles).
module cell_exerciser
  import cell_exerciser_pkg::*;
#(
  parameter int NUM_CELLS     = 24,
  parameter int MAX_IN        = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [$clog2(NUM_CELLS)-1:0]  cell_sel_i,
  input  logic [$clog2(MAX_IN+1)-1:0]   num_in_i,
  input  logic [2**MAX_IN-1:0]          exp_tt_i,
  input  logic [7:0]                    passes_i,
  output logic [NUM_CELLS*MAX_IN-1:0]   cell_in_o,
  input  logic [NUM_CELLS-1:0]          cell_y_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          cfg_err_o,
  output logic                          aborted_o,
  output logic [2**MAX_IN-1:0]          capt_tt_o,
  output logic [ERR_W-1:0]              err_cnt_o
);

  localparam int SEL_W   = $clog2(NUM_CELLS);
  localparam int NIN_W   = $clog2(MAX_IN+1);
  localparam int TT_BITS = 2**MAX_IN;
  localparam int CIN_W   = NUM_CELLS*MAX_IN;
`ifdef CELL_EXERCISER_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
  localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
  localparam int SCNT_W = $clog2(SETTLE_LEN+1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NIN_W-1:0]     nin_q, nin_d;
  logic [TT_BITS-1:0]   exp_q, exp_d;
  logic [7:0]           passes_q, passes_d;
  logic [MAX_IN-1:0]    vec_q, vec_d;
  logic [SCNT_W-1:0]    scnt_q, scnt_d;
  logic [7:0]           pass_q, pass_d;
  logic [CIN_W-1:0]     cell_in_q, cell_in_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 aborted_q, aborted_d;
  logic [TT_BITS-1:0]   capt_q, capt_d;
  logic [ERR_W-1:0]     err_q, err_d;

  logic [NUM_CELLS-1:0] y_src;
  logic                 y;
  logic                 cfg_bad;
  logic                 last_vec;
  logic [MAX_IN:0]      last_v;
  logic [31:0]          err_inc;
  logic                 running;

`ifdef CELL_EXERCISER_SYNC_EN
  cell_exerciser_sync #(
    .W (NUM_CELLS)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cell_y_i),
    .q_o   (y_src)
  );
`else
  assign y_src = cell_y_i;
`endif

  assign y = y_src[sel_q];

  assign cfg_bad = (32'(cell_sel_i) >= 32'(NUM_CELLS))
                || (num_in_i == '0)
                || (32'(num_in_i) > 32'(MAX_IN));

  assign last_v   = ((MAX_IN+1)'(1) << nin_q) - (MAX_IN+1)'(1);
  assign last_vec = ({1'b0, vec_q} == last_v);
  assign err_inc  = sat_inc(32'(err_q), ERR_W);

  assign running = (state_q == S_DRIVE)
                || (state_q == S_SETTLE)
                || (state_q == S_SAMPLE);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    nin_d     = nin_q;
    exp_d     = exp_q;
    passes_d  = passes_q;
    vec_d     = vec_q;
    scnt_d    = scnt_q;
    pass_d    = pass_q;
    cell_in_d = cell_in_q;
    done_d    = 1'b0;
    cfg_err_d = cfg_err_q;
    aborted_d = aborted_q;
    capt_d    = capt_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sel_d     = cell_sel_i;
          nin_d     = num_in_i;
          exp_d     = exp_tt_i;
          passes_d  = passes_i;
          err_d     = '0;
          capt_d    = '0;
          cfg_err_d = 1'b0;
          aborted_d = 1'b0;
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            vec_d   = '0;
            pass_d  = '0;
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        scnt_d  = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt_q == SCNT_W'(SETTLE_LEN-1)) begin
          state_d = S_SAMPLE;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        capt_d[vec_q] = y;
        if (y != exp_q[vec_q]) err_d = err_inc[ERR_W-1:0];
        if (last_vec) begin
          pass_d = pass_q + 8'd1;
          if ((passes_q != 8'd0) && (pass_d == passes_q)) begin
            state_d = S_DONE;
          end else begin
            vec_d   = '0;
            state_d = S_DRIVE;
          end
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && running) begin
      state_d   = S_DONE;
      aborted_d = 1'b1;
    end

    // Drive only changes on entry to DRIVE; everything else idles at 0.
    if ((state_d == S_DRIVE) && (state_q != S_DRIVE)) begin
      for (int k = 0; k < NUM_CELLS; k++) begin
        cell_in_d[k*MAX_IN +: MAX_IN] =
          (32'(sel_d) == k) ? vec_d : '0;
      end
    end else if ((state_d == S_DONE) || (state_d == S_IDLE)) begin
      cell_in_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      nin_q     <= '0;
      exp_q     <= '0;
      passes_q  <= '0;
      vec_q     <= '0;
      scnt_q    <= '0;
      pass_q    <= '0;
      cell_in_q <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      aborted_q <= 1'b0;
      capt_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      nin_q     <= nin_d;
      exp_q     <= exp_d;
      passes_q  <= passes_d;
      vec_q     <= vec_d;
      scnt_q    <= scnt_d;
      pass_q    <= pass_d;
      cell_in_q <= cell_in_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      aborted_q <= aborted_d;
      capt_q    <= capt_d;
      err_q     <= err_d;
    end
  end

  assign cell_in_o = cell_in_q;
  assign busy_o    = running;
  assign done_o    = done_q;
  assign cfg_err_o = cfg_err_q;
  assign aborted_o = aborted_q;
  assign capt_tt_o = capt_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_cell_exerciser.sv
// Bench for cell_exerciser: behavioural cell models plus a run-level
// model of capture, error count and start-to-done latency.
module tb_cell_exerciser;

  localparam int NC = 24;
  localparam int MI = 4;
  localparam int SC = 4;
`ifdef CELL_EXERCISER_SYNC_EN
  localparam int COST = SC + 4;
`else
  localparam int COST = SC + 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start4 = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  sel = '0;
  logic [2:0]  nin = '0;
  logic [15:0] exp_tt = '0;
  logic [7:0]  passes = '0;

  logic [95:0] cin0, cin4;
  logic [23:0] y0, y4;
  logic        busy0, busy4, done0, done4;
  logic        cfg0, cfg4, ab0, ab4;
  logic [15:0] capt0, capt4;
  logic [15:0] err0;
  logic [3:0]  err4;

  int mode0 = 0;
  int mode4 = 0;
  logic which = 1'b0;
  int cur_sel = 0;
  int cur_n = 2;
  bit mon_en = 1'b0;

  int total = 0;
  int passed = 0;
  int last_lat = 0;

  always #5 clk = ~clk;

  cell_exerciser #(
    .NUM_CELLS(NC), .MAX_IN(MI), .SETTLE_CYCLES(SC), .ERR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(abort),
    .cell_sel_i(sel), .num_in_i(nin), .exp_tt_i(exp_tt),
    .passes_i(passes), .cell_in_o(cin0), .cell_y_i(y0),
    .busy_o(busy0), .done_o(done0), .cfg_err_o(cfg0),
    .aborted_o(ab0), .capt_tt_o(capt0), .err_cnt_o(err0)
  );

  cell_exerciser #(
    .NUM_CELLS(NC), .MAX_IN(MI), .SETTLE_CYCLES(SC), .ERR_W(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .abort_i(abort),
    .cell_sel_i(sel), .num_in_i(nin), .exp_tt_i(exp_tt),
    .passes_i(passes), .cell_in_o(cin4), .cell_y_i(y4),
    .busy_o(busy4), .done_o(done4), .cfg_err_o(cfg4),
    .aborted_o(ab4), .capt_tt_o(capt4), .err_cnt_o(err4)
  );

  // Cell models: 0 AND2, 1 XOR2, 2 stuck-at-1, 3 stuck-at-0.
  function automatic logic f(input int m, input logic [3:0] v);
    case (m)
      0:       return v[0] & v[1];
      1:       return v[0] ^ v[1];
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    y0 = '0;
    y4 = '0;
    for (int k = 0; k < NC; k++) begin
      y0[k] = f(mode0, cin0[k*4 +: 4]);
      y4[k] = f(mode4, cin4[k*4 +: 4]);
    end
  end

  wire        busy_m = which ? busy4 : busy0;
  wire        done_m = which ? done4 : done0;
  wire        cfg_m  = which ? cfg4  : cfg0;
  wire        ab_m   = which ? ab4   : ab0;
  wire [15:0] capt_m = which ? capt4 : capt0;
  wire [15:0] err_m  = which ? {12'd0, err4} : err0;
  wire [95:0] cin_m  = which ? cin4  : cin0;
  wire [95:0] cin_o  = which ? cin0  : cin4;

  task automatic chk(input string nm, input longint got,
                     input longint expv);
    total++;
    if (got == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d @%0t",
                  nm, got, expv, $time);
  endtask

  // Drive-shape and capture-width invariants, every cycle.
  always @(negedge clk) begin
    logic [127:0] mask;
    if (rst_n && mon_en) begin
      mask = '0;
      if (busy_m)
        mask = ((128'd1 << cur_n) - 128'd1) << (cur_sel * 4);
      chk("cin_shape", longint'(|(cin_m & ~mask[95:0])), 0);
      chk("cin_other", longint'(|cin_o), 0);
      chk("capt_hi", longint'(capt_m >> (1 << cur_n)), 0);
    end
  end

  task automatic run(input logic w, input int s, input int n,
                     input logic [15:0] e, input int p, input int m,
                     input int abort_k, input int glitch_k);
    int L, full_l, nsamp, errs, emax, got, v;
    logic [15:0] ec;
    logic ea, bad;
    @(negedge clk);
    which = w;
    if (w) mode4 = m; else mode0 = m;
    sel = 5'(s); nin = 3'(n); exp_tt = e; passes = 8'(p);
    cur_sel = s; cur_n = n;
    if (w) start4 = 1'b1; else start0 = 1'b1;

    bad = (s >= NC) || (n == 0) || (n > MI);
    ea = 1'b0;
    if (bad) begin
      L = 1; nsamp = 0;
    end else begin
      full_l = (1 << n) * p * COST + 1;
      if (abort_k >= 0 && (p == 0 || abort_k <= full_l - 2)) begin
        L = abort_k + 2;
        nsamp = (abort_k + 1) / COST;
        ea = 1'b1;
      end else begin
        L = full_l;
        nsamp = (1 << n) * p;
      end
    end
    emax = w ? 15 : 65535;
    ec = '0; errs = 0;
    for (int i = 0; i < nsamp; i++) begin
      v = i % (1 << n);
      ec[v] = f(m, 4'(v));
      if (f(m, 4'(v)) != e[v]) errs++;
    end
    if (errs > emax) errs = emax;

    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start4 = 1'b0;
    got = -1;
    for (int k = 0; k < L + 10; k++) begin
      if (k > 0) @(negedge clk);
      abort = (k == abort_k);
      if (k == glitch_k) begin
        sel = 5'd30;
        if (w) start4 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start4 = 1'b0;
      end
      chk("busy", longint'(busy_m), longint'(k < L - 1));
      if (done_m) begin
        got = k;
        break;
      end
    end
    abort = 1'b0; start0 = 1'b0; start4 = 1'b0;
    last_lat = got;
    chk("latency", got, L);
    chk("cfg_err", longint'(cfg_m), longint'(bad));
    chk("aborted", longint'(ab_m), longint'(ea));
    chk("capt_tt", longint'(capt_m), longint'(ec));
    chk("err_cnt", longint'(err_m), errs);
    @(negedge clk);
    chk("done_pulse", longint'(done_m), 0);
  endtask

  initial begin
    int nd;
    #1;
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_done", longint'(done0), 0);
    chk("rst_capt", longint'(capt0), 0);
    chk("rst_err", longint'(err0), 0);
    chk("rst_cin", longint'(|cin0), 0);
    chk("rst_flags", longint'({cfg0, ab0}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    run(1'b0, 0, 2, 16'h0008, 1, 0, -1, -1);
    chk("and2_capt_lit", longint'(capt0), 16'h0008);
    chk("and2_err_lit", longint'(err0), 0);
`ifndef CELL_EXERCISER_SYNC_EN
    chk("and2_lat_lit", last_lat, 25);
`endif

    run(1'b0, 0, 2, 16'h0008, 1, 2, -1, -1);
    chk("s1_capt_lit", longint'(capt0), 16'h000F);
    chk("s1_err_lit", longint'(err0), 3);
    run(1'b0, 0, 2, 16'h0008, 5, 2, -1, -1);
    chk("s1x5_err_lit", longint'(err0), 15);

    run(1'b0, 30, 2, 16'h0008, 1, 0, -1, -1);
    chk("sel_bad_lit", longint'(cfg0), 1);
    chk("sel_bad_lat", last_lat, 1);
    run(1'b0, 3, 0, 16'h0008, 1, 0, -1, -1);
    chk("nin0_lit", longint'(cfg0), 1);

    run(1'b0, 7, 2, 16'h0006, 0, 1, 40, 10);
    chk("xor_ab_lit", longint'(ab0), 1);
    chk("xor_capt_lit", longint'(capt0), 16'h0006);
    chk("xor_err_lit", longint'(err0), 0);

    // Reset in the middle of vector 3's settle window.
    @(negedge clk);
    which = 1'b0; mode0 = 2; cur_sel = 0; cur_n = 2;
    sel = 5'd0; nin = 3'd2; exp_tt = 16'h0008; passes = 8'd1;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_err", longint'(err0), 3);
    chk("pre_rst_busy", longint'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", longint'({busy0, done0, cfg0, ab0}), 0);
    chk("mid_rst_capt", longint'(capt0), 0);
    chk("mid_rst_err", longint'(err0), 0);
    chk("mid_rst_cin", longint'(|cin0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done0 || busy0) nd++;
    end
    chk("post_rst_quiet", nd, 0);
    run(1'b0, 0, 2, 16'h0008, 1, 0, -1, -1);

    run(1'b1, 0, 2, 16'h000E, 0, 3, 8 * 4 * COST - 1, -1);
    chk("sat_err_lit", longint'(err4), 15);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cell_exerciser.md
Name: cell_exerciser

Overview:
- Per-cell functional exerciser for the standard-cell testwafer macro.
- Software selects one cell, its input count and expected truth table. The block applies every input vector, waits a settle time, samples the cell output and compares it against the expected value. It accumulates a captured truth table and an error count over a programmable number of passes.
- Sits between the register/logic-analyser interface and the instantiated cell array.

Parameters:
- NUM_CELLS, 24, number of cells under test; each has one output bit.
- MAX_IN, 4, maximum cell input count; the truth table width is 2**MAX_IN.
- SETTLE_CYCLES, 4, clock cycles each vector is held before sampling (min 1).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- abort_i  in  1  stop the run at the end of the current cycle
- cell_sel_i  in  $clog2(NUM_CELLS)  index of the cell under test
- num_in_i  in  $clog2(MAX_IN+1)  input count of the selected cell, valid range 1..MAX_IN
- exp_tt_i  in  2**MAX_IN  expected output; bit v is the expected Y for vector v
- passes_i  in  8  pass count; 0 means run until abort
- cell_in_o  out  NUM_CELLS*MAX_IN  per-cell input drive; cell k owns slice [k*MAX_IN +: MAX_IN]
- cell_y_i  in  NUM_CELLS  cell outputs
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at run end
- cfg_err_o  out  1  last start had an illegal configuration
- aborted_o  out  1  last run ended by abort
- capt_tt_o  out  2**MAX_IN  captured outputs of the most recent pass
- err_cnt_o  out  ERR_W  total mismatches; saturates at all-ones

Behaviour:
- Reset (async, rst_n low) values:
  - all outputs 0;
  - state IDLE;
  - vector, settle and pass counters 0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: on start_i:
  - latch cell_sel_i, num_in_i, exp_tt_i and passes_i;
  - clear err_cnt_o, capt_tt_o, cfg_err_o and aborted_o;
  - if cell_sel_i >= NUM_CELLS, num_in_i == 0 or num_in_i > MAX_IN: set cfg_err_o and go to DONE;
  - otherwise go to DRIVE with vector = 0 and pass = 0.
- DRIVE (1 cycle): register vector into the selected cell's slice (upper unused bits 0); go to SETTLE.
- SETTLE: hold for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - write y = cell_y_i[sel] into capt_tt_o[vector];
  - if y != exp_tt_i[vector], increment err_cnt_o (saturating);
  - if vector < 2**num_in-1: vector++ and go to DRIVE;
  - else (end of pass): pass++; if passes != 0 and pass == passes, go to DONE; else vector = 0 and go to DRIVE.
- DONE (1 cycle): done_o = 1; clear all cell_in_o drive; go to IDLE.
- Cost per vector: SETTLE_CYCLES+2 cycles.
- Start-to-done_o latency: 2**num_in * passes * (SETTLE_CYCLES+2) + 1 cycles, measured from the start_i sample edge.
- busy_o is high in DRIVE, SETTLE and SAMPLE.
- cell_in_o:
  - non-selected slices are always 0;
  - the selected slice changes only on DRIVE entry;
  - all slices are 0 in IDLE and DONE.
- capt_tt_o bits >= 2**num_in stay 0. Bits persist across passes: each pass overwrites the same indices.
- abort_i has priority over every transition in DRIVE, SETTLE and SAMPLE:
  - go to DONE and set aborted_o;
  - an abort in the same cycle as SAMPLE still records that sample;
  - abort_i in IDLE is ignored;
  - start_i while busy is ignored.
- Status outputs (cfg_err_o, aborted_o, capt_tt_o, err_cnt_o) hold until the next accepted start.
- Reset mid-run: immediate return to IDLE with all outputs 0; no done_o pulse.

Optional Feature:
- CELL_EXERCISER_SYNC_EN defined:
  - cell_y_i passes through a 2-flop synchroniser (reset 0) before sampling;
  - SETTLE holds SETTLE_CYCLES+2 cycles, so the per-vector cost is SETTLE_CYCLES+4.
  - Intended for cells with slow or asynchronous outputs.
- Undefined: cell_y_i is sampled directly; timing is as stated in Behaviour.

Decomposition:
- Package cell_exerciser_pkg:
  - state enum (IDLE/DRIVE/SETTLE/SAMPLE/DONE);
  - localparam TT_W = 2**MAX_IN default;
  - saturating-increment function.
- One sub-module, cell_exerciser_sync: parametrised-width 2-flop synchroniser. Instantiated only under CELL_EXERCISER_SYNC_EN.

Test Plan:
- AND2 behavioural model on cell 0, num_in=2, exp_tt=0x0008, passes=1, SETTLE=4 -> capt_tt=0x0008, err_cnt=0, done_o exactly 25 cycles after start, cfg_err=0.
- Same setup but the model is stuck-at-1 -> capt_tt=0x000F, err_cnt=3; with passes=5 -> err_cnt=15.
- cell_sel=30 (NUM_CELLS=24), or num_in=0 -> cfg_err=1, done_o 1 cycle after start, cell_in_o stays 0, busy_o never high.
- XOR2 model, passes=0, abort_i asserted 40 cycles after start -> aborted_o=1, done_o next cycle, err_cnt=0, capt_tt=0x0006; a start during busy has no effect.
- rst_n pulsed low mid-SETTLE -> all outputs 0 immediately, no done_o; a new start then runs normally.
- ERR_W=4, stuck-at-0 model on AND2 with exp_tt=0x000E (OR2), passes=0, abort after 8 passes -> err_cnt saturates at 15.
